// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid register: FSM encodings and default payload width.
package pipe_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Encoding doubles as the entry count, so occupancy is the state itself.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_data_reg.sv
// WIDTH-bit payload register with load enable, synchronous clear and asynchronous reset to RST_VAL.
module pipe_data_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH   = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      q <= RST_VAL;
    end else if (clr) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline register stage with optional two-entry skid buffer, hold (stall) and flush.
// Handshake: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH   = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               SKID    = 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             flush_in,
  input  logic             hold_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  pipe_state_e      state_q, state_d;
  logic             in_fire, out_fire;
  logic             main_load, skid_load;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;

  assign out_valid = (state_q != ST_EMPTY) && !hold_in;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign occupancy = state_q;

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = in_data;
    // Hold needs no branch: it gates both fires, so nothing moves.
    if (flush_in) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d   = ST_BUSY;
            main_load = 1'b1;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end else if (in_fire && (SKID != 0)) begin
            state_d   = ST_FULL;
            skid_load = 1'b1;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d   = ST_BUSY;
            main_load = 1'b1;
            main_d    = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      // Registered ready tracks "not FULL" of the next state, so it never sees out_ready combinationally.
      logic rdy_q;
      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
          rdy_q <= 1'b0;
        end else begin
          rdy_q <= (state_d != ST_FULL);
        end
      end
      assign in_ready = rdy_q && !hold_in && !flush_in;
    end else begin : g_pass
      assign in_ready = (!out_valid || out_ready) && !hold_in && !flush_in;
    end
  endgenerate

  pipe_data_reg #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_main (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clr    (flush_in),
    .load   (main_load),
    .d      (main_d),
    .q      (out_data)
  );

  pipe_data_reg #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_skid (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clr    (flush_in),
    .load   (skid_load),
    .d      (in_data),
    .q      (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg (SKID=1) with a small in-order scoreboard on the output side.
module tb_pipe_skid_reg;

  localparam int          W   = 32;
  localparam logic [W-1:0] RV = 32'h0BAD_F00D;

  logic         clk_in = 1'b0;
  logic         rst_in, flush_in, hold_in, in_valid, out_ready;
  logic         in_ready, out_valid;
  logic [W-1:0] in_data, out_data;
  logic [1:0]   occupancy;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  pipe_skid_reg #(.WIDTH(W), .RST_VAL(RV), .SKID(1)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .flush_in  (flush_in),
    .hold_in   (hold_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Settle, record what transfers at the coming edge, then advance one cycle.
  task automatic cycle();
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("sb_underflow", 1, 0);
      else check("sb_data", out_data, exp_q.pop_front());
    end
    if (in_valid && in_ready) exp_q.push_back(in_data);
    tick();
  endtask

  task automatic push(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    cycle();
    in_valid = 1'b0;
    in_data  = 'x;
  endtask

  initial begin
    int outs, ins, max_occ, stale;
    rst_in = 1'b1; flush_in = 1'b0; hold_in = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

    // Reset state
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_occ", occupancy, 0);
    check("rst_out_data", out_data, RV);
    check("rst_in_ready", in_ready, 0);
    repeat (2) tick();
    rst_in = 1'b0;
    #1;
    check("rel_in_ready_low", in_ready, 0);
    tick();
    check("rel_in_ready_high", in_ready, 1);

    // Single push, one-cycle latency
    out_ready = 1'b1;
    push(32'hDEAD_BEEF);
    check("single_out_valid", out_valid, 1);
    check("single_out_data", out_data, 32'hDEAD_BEEF);
    check("single_occ1", occupancy, 1);
    cycle();
    check("single_occ0", occupancy, 0);
    check("single_empty", out_valid, 0);

    // Backpressure into the skid entry
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h1;
    cycle();
    check("bp_occ1", occupancy, 1);
    check("bp_ready1", in_ready, 1);
    in_data = 32'h2;
    cycle();
    check("bp_occ2", occupancy, 2);
    check("bp_ready_drop", in_ready, 0);
    check("bp_head", out_data, 32'h1);
    in_data = 32'h3;
    cycle();
    check("bp_stay_full", occupancy, 2);
    out_ready = 1'b1;
    cycle();
    check("bp_second", out_data, 32'h2);
    check("bp_ready_back", in_ready, 1);
    cycle();
    in_valid = 1'b0;
    check("bp_third", out_data, 32'h3);
    check("bp_third_occ", occupancy, 1);
    cycle();
    check("bp_drained", occupancy, 0);

    // Streaming 100 back-to-back
    outs = 0; ins = 0; max_occ = 0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h1000 + i;
      #1;
      if (in_ready) ins++;
      if (out_valid) outs++;
      if (occupancy > max_occ) max_occ = occupancy;
      cycle();
    end
    in_valid = 1'b0;
    #1;
    if (out_valid) outs++;
    cycle();
    check("stream_ins", ins, 100);
    check("stream_outs", outs, 100);
    check("stream_max_occ", max_occ, 1);
    check("stream_empty", occupancy, 0);
    check("stream_sb_empty", exp_q.size(), 0);

    // Hold with two entries
    out_ready = 1'b0;
    push(32'hA1);
    push(32'hA2);
    check("hold_pre_occ", occupancy, 2);
    hold_in = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'hA3;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("hold_out_valid", out_valid, 0);
      check("hold_in_ready", in_ready, 0);
      check("hold_occ", occupancy, 2);
      check("hold_data", out_data, 32'hA1);
      cycle();
    end
    hold_in = 1'b0; in_valid = 1'b0;
    #1;
    check("hold_rel_head", out_data, 32'hA1);
    cycle();
    check("hold_rel_second", out_data, 32'hA2);
    cycle();
    check("hold_rel_empty", occupancy, 0);

    // Flush beats hold and a pending input
    out_ready = 1'b0;
    push(32'hB1);
    push(32'hB2);
    check("flush_pre_occ", occupancy, 2);
    flush_in = 1'b1; hold_in = 1'b1;
    in_valid = 1'b1; in_data = 32'h77;
    #1;
    check("flush_in_ready", in_ready, 0);
    tick();
    flush_in = 1'b0; hold_in = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    #1;
    check("flush_occ", occupancy, 0);
    check("flush_data", out_data, RV);
    check("flush_valid", out_valid, 0);
    // Skid path still ordered after flush
    push(32'hC1);
    push(32'hC2);
    out_ready = 1'b1;
    #1;
    check("post_flush_head", out_data, 32'hC1);
    cycle();
    check("post_flush_second", out_data, 32'hC2);
    cycle();

    // Async reset between edges
    out_ready = 1'b0;
    push(32'hD1);
    push(32'hD2);
    in_valid = 1'b1; in_data = 32'h55;
    #2;
    rst_in = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_occ", occupancy, 0);
    check("arst_data", out_data, RV);
    check("arst_ready", in_ready, 0);
    exp_q.delete();
    tick();
    rst_in = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (out_valid) stale++;
      cycle();
    end
    check("arst_no_stale", stale, 0);
    check("arst_ready_back", in_ready, 1);
    push(32'hCAFE);
    check("arst_new_data", out_data, 32'hCAFE);
    cycle();
    check("arst_final_empty", occupancy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 32: payload width in bits, legal range 1..128.
REQ-002 The block SHALL expose parameter RST_VAL, default 0: value loaded into both data registers on reset and on flush.
REQ-003 The block SHALL expose parameter SKID, default 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with pass-through ready.
REQ-004 The block SHALL have these ports:
- clk_in  input  1  clock, rising-edge.
- rst_in  input  1  reset, asynchronous, active-high.
- flush_in  input  1  synchronous flush; drops all entries.
- hold_in  input  1  stall; freezes all state (PC_remain generalised).
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  block can accept a payload.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  payload to downstream.
- occupancy  output  2  entry count, 0..2.

Function
REQ-005 An input transfer SHALL occur when in_valid && in_ready at a rising edge; an output transfer when out_valid && out_ready.
REQ-006 The FSM SHALL have states EMPTY (0 entries), BUSY (1), FULL (2); FULL is unreachable when SKID=0.
REQ-007 Transitions:
- EMPTY -> BUSY on input transfer.
- BUSY -> EMPTY on output transfer without input transfer.
- BUSY -> BUSY on both transfers, or on neither.
- BUSY -> FULL on input transfer without output transfer (SKID=1).
- FULL -> BUSY on output transfer.
REQ-008 Latency SHALL be exactly 1 cycle from input transfer to out_valid=1 when entering from EMPTY; sustained throughput SHALL be 1 transfer/cycle.
REQ-009 out_data SHALL always come from the main register; the skid register SHALL capture in_data only on the BUSY -> FULL transition.
REQ-010 On FULL -> BUSY, the skid register SHALL move into the main register; ordering SHALL be strictly FIFO.
REQ-011 When SKID=1, in_ready SHALL be a register output equal to (state != FULL), with no combinational path from out_ready.
REQ-012 When SKID=0, in_ready SHALL be !out_valid || out_ready.
REQ-013 out_valid SHALL equal (state != EMPTY) && !hold_in; occupancy SHALL equal the entry count.
REQ-014 While hold_in=1: in_ready SHALL be forced to 0, out_valid SHALL be masked to 0, and state and data SHALL be unchanged.
REQ-015 flush_in=1 SHALL force state to EMPTY and both data registers to RST_VAL at the next edge, with priority over hold_in and over any concurrent transfer.
REQ-016 While flush_in=1, in_ready SHALL be 0, so no input is accepted in the flush cycle.
REQ-017 Data registers SHALL load only on transfers or flush; X on in_data while in_valid=0 SHALL never propagate to out_data.

Reset
REQ-018 rst_in=1 SHALL immediately force state EMPTY, out_valid=0, occupancy=0, out_data=RST_VAL and the skid register to RST_VAL.
REQ-019 During reset, in_ready SHALL be 0 (registered form cleared); it SHALL rise on the first clk_in edge after rst_in deasserts.
REQ-020 Reset asserted mid-transfer SHALL discard all entries; no payload SHALL appear after reset release.

Structure
REQ-021 FSM state encodings (EMPTY=2'd0, BUSY=2'd1, FULL=2'd2) and the default WIDTH SHALL live in the shared package pipe_pkg.
REQ-022 One sub-module, pipe_data_reg (a WIDTH-bit register with load enable and sync/async clear to RST_VAL), SHALL be instantiated for the main and skid entries.

Verification
REQ-023 Reset then single push: in_data=0xDEADBEEF, in_valid for 1 cycle, out_ready=1 -> out_valid=1 the next cycle with out_data=0xDEADBEEF, occupancy 1 then 0.
REQ-024 Backpressure (SKID=1): push 0x1, 0x2, 0x3 with out_ready=0 -> in_ready drops after the 2nd accept, occupancy=2; release out_ready -> output sequence 0x1, 0x2, then 0x3 accepted.
REQ-025 Streaming: 100 back-to-back pushes with out_ready=1 -> 100 outputs in order at 1 per cycle, occupancy never 2.
REQ-026 Hold: occupancy=2, assert hold_in for 5 cycles with out_ready=1 -> out_valid=0, in_ready=0, contents unchanged; after release, data is output in the original order.
REQ-027 Flush with hold_in=1 and in_valid=1 at occupancy=2 -> next cycle occupancy=0, out_data=RST_VAL, and the payload is not accepted.
REQ-028 Async reset mid-stream (rst_in pulse between edges) -> outputs clear immediately, and no stale payload appears after release.
